mux4: RTL and testbench

MUX4 -- requirements
Module: mux4

---
 rtl/mux4_pkg.sv | 15 +
 rtl/mux4_core.sv | 28 ++
 rtl/mux4.sv | 106 ++++++++++
 tb/tb_mux4.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// Shared types and constants for the 4:1 selector block: select encoding and
// default counter width.
package mux4_pkg;

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_D = 2'd3
  } sel_t;

  localparam int CNT_W_DEFAULT = 8;
  localparam int NUM_IN        = 4;

endpackage : mux4_pkg

// File: rtl/mux4_core.sv
// Purely combinational 4:1 selector. An unknown select code drives an unknown
// result so simulation exposes undriven selects instead of masking them.
module mux4_core
  import mux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  // select one data input from the 2-bit code
  always_comb begin
    y = {WIDTH{1'b0}};
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = {WIDTH{1'bx}};
    endcase
  end

endmodule : mux4_core

// File: rtl/mux4.sv
// 4:1 selector with a registered output, a registered valid flag and four
// saturating per-input selection counters.
module mux4
  import mux4_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             sel1,
  input  logic             sel0,
  input  logic             in_valid,
  input  logic [1:0]       cnt_idx,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt_out
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1'b1);
    end
    return r;
  endfunction

  logic [1:0]       sel_s;
  logic [WIDTH-1:0] y_s;
  logic [WIDTH-1:0] y_reg_d, y_reg_q;
  logic             out_valid_d, out_valid_q;
  logic [CNT_W-1:0] cnt_d [NUM_IN];
  logic [CNT_W-1:0] cnt_q [NUM_IN];

  assign sel_s = {sel1, sel0};

  mux4_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel_s),
    .y   (y_s)
  );

  assign y = y_s;

  // next state of the output register and valid flag; reset wins over traffic
  always_comb begin
    y_reg_d     = y_reg_q;
    out_valid_d = out_valid_q;
    if (!rst) begin
      y_reg_d     = {WIDTH{1'b0}};
      out_valid_d = 1'b0;
    end else begin
      y_reg_d     = y_s;
      out_valid_d = in_valid;
    end
  end

  // next state of the counters: only the selected one moves, and only on valid
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (!rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end
    end else if (in_valid) begin
      case (sel_s)
        SEL_A:   cnt_d[0] = sat_inc(cnt_q[0]);
        SEL_B:   cnt_d[1] = sat_inc(cnt_q[1]);
        SEL_C:   cnt_d[2] = sat_inc(cnt_q[2]);
        SEL_D:   cnt_d[3] = sat_inc(cnt_q[3]);
        default: cnt_d[0] = cnt_q[0];
      endcase
    end else begin
      cnt_d[0] = cnt_q[0];
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    y_reg_q     <= y_reg_d;
    out_valid_q <= out_valid_d;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_q[i] <= cnt_d[i];
    end
  end

  assign y_q       = y_reg_q;
  assign out_valid = out_valid_q;
  assign cnt_out   = cnt_q[cnt_idx];

endmodule : mux4

// File: tb/tb_mux4.sv
// Bench for mux4: a 1-bit/8-bit-counter instance and an 8-bit/2-bit-counter
// instance share select, valid and reset; registered results go through a queue.
`timescale 1ns/1ps
module tb_mux4;

  logic       clk = 1'b0;
  logic       rst, sel1, sel0, in_valid;
  logic [1:0] cnt_idx;
  logic       a1, b1, c1, d1;
  logic       y1, yq1, ov1;
  logic [7:0] cnt1;
  logic [7:0] a8, b8, c8, d8, y8, yq8;
  logic       ov8;
  logic [1:0] cnt8;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q [$];

  always #5 clk = ~clk;

  mux4 #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1),
    .sel1(sel1), .sel0(sel0), .in_valid(in_valid), .cnt_idx(cnt_idx),
    .y(y1), .y_q(yq1), .out_valid(ov1), .cnt_out(cnt1)
  );

  mux4 #(.WIDTH(8), .CNT_W(2)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8),
    .sel1(sel1), .sel0(sel0), .in_valid(in_valid), .cnt_idx(cnt_idx),
    .y(y8), .y_q(yq8), .out_valid(ov8), .cnt_out(cnt8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; dat = {a,b,c,d} for the 1-bit instance.
  task automatic step(input logic [1:0] s, input logic [3:0] dat, input logic v,
                      input logic r, input logic eyq, input logic eov);
    @(negedge clk);
    {sel1, sel0} = s;
    {a1, b1, c1, d1} = dat;
    in_valid = v;
    rst = r;
    exp_q.push_back({eyq, eov});
    @(posedge clk);
  endtask

  task automatic check_cnts(input string name, input int e1 [4], input int e8 [4]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt_idx = i[1:0];
      #1;
      chk({name, "_c1"}, 32'(cnt1), 32'(e1[i]));
      chk({name, "_c8"}, 32'(cnt8), 32'(e8[i]));
    end
  endtask

  // Monitor: one expected registered response per stimulated edge.
  always @(posedge clk) begin
    logic [1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("y_q", 32'(yq1), 32'(e[1]));
      chk("out_valid", 32'(ov1), 32'(e[0]));
    end
  end

  initial begin
    logic [7:0] wexp [4];
    logic       e;
    int         drain;
    wexp = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b0; sel1 = 1'b0; sel0 = 1'b0; in_valid = 1'b0; cnt_idx = 2'd0;
    {a1, b1, c1, d1} = 4'b0000;
    a8 = 8'h00; b8 = 8'h00; c8 = 8'h00; d8 = 8'h00;

    // power-up reset
    step(2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check_cnts("reset", '{0, 0, 0, 0}, '{0, 0, 0, 0});

    // exhaustive combinational sweep, independent of the clock
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      {sel1, sel0, a1, b1, c1, d1} = i[5:0];
      #17;
      case (i[5:4])
        2'b00:   e = i[3];
        2'b01:   e = i[2];
        2'b10:   e = i[1];
        default: e = i[0];
      endcase
      chk("comb_sweep", 32'(y1), 32'(e));
      #18;
    end
    {sel1, sel0, a1, b1, c1, d1} = 6'b10_0010; #2;
    chk("comb_ex1", 32'(y1), 32'd1);
    {sel1, sel0, a1, b1, c1, d1} = 6'b11_1110; #2;
    chk("comb_ex2", 32'(y1), 32'd0);

    // registered path: one valid beat, then idle
    step(2'b00, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1);
    step(2'b00, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0);

    // reset beats an in-flight valid; y stays live during reset
    step(2'b10, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_y_live", 32'(y1), 32'd1);
    check_cnts("rst_valid", '{0, 0, 0, 0}, '{0, 0, 0, 0});

    // counters: selects 00,01,01,11,11,11 with a=1,b=0,c=1,d=0
    step(2'b00, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b1);
    step(2'b01, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b1);
    step(2'b01, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b1);
    step(2'b11, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b1);
    step(2'b11, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b1);
    step(2'b11, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b1);
    check_cnts("count", '{1, 2, 0, 3}, '{1, 2, 0, 3});

    // saturation of the 2-bit counters on select 10
    for (int i = 0; i < 5; i++) step(2'b10, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b1);
    check_cnts("sat5", '{1, 2, 5, 3}, '{1, 2, 3, 3});
    step(2'b10, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b1);
    check_cnts("sat6", '{1, 2, 6, 3}, '{1, 2, 3, 3});

    // mid-stream reset, then resume on the first released edge
    step(2'b01, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b01, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1);
    check_cnts("resume", '{0, 1, 0, 0}, '{0, 1, 0, 0});

    // 8-bit data path
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
    for (int i = 0; i < 4; i++) begin
      {sel1, sel0} = i[1:0];
      #2;
      chk("width8_y", 32'(y8), 32'(wexp[i]));
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 5) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() > 0) chk("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux4
